// File: rtl/std_cache_pkg.sv
// -----------------------------------------------------------------------------
// std_cache_pkg
//   Shared types for the L1 data cache request ports and the committed-store
//   drain queue.
//
//   dcache_req_i_t      : request bundle driven into a cache port
//   dcache_req_o_t      : response bundle returned by a cache port
//   store_drain_entry_t : one buffered committed store
//   drain_state_e       : drain FSM state
// -----------------------------------------------------------------------------
package std_cache_pkg;

    localparam int unsigned PADDR_W = 56;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = 8;
    localparam int unsigned INDEX_W = 12;
    localparam int unsigned TAG_W   = PADDR_W - INDEX_W;

    typedef struct packed {
        logic [INDEX_W-1:0] address_index;
        logic [TAG_W-1:0]   address_tag;
        logic [DATA_W-1:0]  data_wdata;
        logic               data_req;
        logic               data_we;
        logic [BE_W-1:0]    data_be;
        logic [1:0]         data_size;
        logic               kill_req;
        logic               tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic              data_gnt;
        logic              data_rvalid;
        logic [DATA_W-1:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [DATA_W-1:0]  data;
        logic [BE_W-1:0]    be;
        logic [1:0]         size;
    } store_drain_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        SEND_TAG = 2'd2
    } drain_state_e;

endpackage

// File: rtl/dcache_store_drain.sv
// -----------------------------------------------------------------------------
// dcache_store_drain
//   In-order committed-store queue feeding the L1 data cache store port.
//   Stores are buffered (up to DEPTH) and drained one at a time from the head
//   using the cache's two-phase index/tag request protocol.
//
//   Handshakes:
//     store side : a store is taken on a rising clock edge when valid_i and
//                  ready_o are both high; ready_o depends only on the queue
//                  fill level, never on valid_i.
//     cache side : data_req is held, with every request field stable, until
//                  data_gnt is seen high on a rising edge. The cycle after the
//                  grant carries tag_valid with the tag and data_req low; the
//                  head entry is popped at the end of that cycle.
//
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     valid_i / ready_o      committed-store push handshake
//     paddr_i, data_i,
//     be_i, size_i           store payload
//     page_offset_i          load page offset to check against queued stores
//     page_offset_matches_o  some queued store shares paddr[11:3]
//     empty_o                nothing queued and drain FSM idle
//     req_port_o/req_port_i  cache store port request / response
//     dbg_state              drain FSM state, for observation only
// -----------------------------------------------------------------------------
module dcache_store_drain
    import std_cache_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [55:0]         paddr_i,
    input  logic [63:0]         data_i,
    input  logic [7:0]          be_i,
    input  logic [1:0]          size_i,
    input  logic [11:0]         page_offset_i,
    output logic                page_offset_matches_o,
    output logic                empty_o,
    output dcache_req_i_t       req_port_o,
    input  dcache_req_o_t       req_port_i,
    output drain_state_e        dbg_state
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // Storage and bookkeeping
    // -------------------------------------------------------------------------
    store_drain_entry_t entries_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   count_q;

    drain_state_e       state_q;
    drain_state_e       state_d;

    store_drain_entry_t head;
    logic               not_empty;
    logic               push;
    logic               pop;

    // Read-side response fields carry nothing for stores.
    logic               unused_rsp;
    assign unused_rsp = ^{req_port_i.data_rvalid, req_port_i.data_rdata,
                          page_offset_i[2:0]};

    assign head      = entries_q[rptr_q];
    assign not_empty = (count_q != '0);
    assign ready_o   = (count_q != FULL_COUNT);
    assign push      = valid_i && ready_o;
    // The head leaves the queue at the end of its tag cycle.
    assign pop       = (state_q == SEND_TAG);
    assign empty_o   = !not_empty && (state_q == IDLE);
    assign dbg_state = state_q;

    // Payload storage needs no reset; valid_q qualifies every use of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[wptr_q] <= '{paddr: paddr_i, data: data_i,
                                   be: be_i, size: size_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // A push never targets the slot being popped: a pop needs a
            // non-empty queue and a push needs a non-full one, so the two
            // pointers can only coincide when one of them is blocked.
            if (pop) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + PTR_W'(1);
            end
            if (push) begin
                valid_q[wptr_q] <= 1'b1;
                wptr_q          <= wptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load-after-store offset check over every occupied slot, head included
    // -------------------------------------------------------------------------
    always_comb begin
        page_offset_matches_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (entries_q[i].paddr[11:3] == page_offset_i[11:3])) begin
                page_offset_matches_o = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM: next state
    // IDLE already drives the request when the queue holds something, so a
    // grant seen in IDLE skips straight to the tag phase.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (not_empty) begin
                    state_d = req_port_i.data_gnt ? SEND_TAG : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (req_port_i.data_gnt) begin
                    state_d = SEND_TAG;
                end
            end
            SEND_TAG: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Drain FSM: outputs
    // Request fields come straight from the head slot, which cannot change
    // until the pop, so they stay stable for as long as data_req is high.
    // -------------------------------------------------------------------------
    always_comb begin
        req_port_o = '0;
        if (((state_q == IDLE) && not_empty) || (state_q == WAIT_GNT)) begin
            req_port_o.data_req      = 1'b1;
            req_port_o.data_we       = 1'b1;
            req_port_o.address_index = head.paddr[11:0];
            req_port_o.data_wdata    = head.data;
            req_port_o.data_be       = head.be;
            req_port_o.data_size     = head.size;
        end
        if (state_q == SEND_TAG) begin
            req_port_o.address_tag = head.paddr[55:12];
            req_port_o.tag_valid   = 1'b1;
        end
    end

endmodule
